uart_tx_dois_bytes: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_dois_bytes_if.sv | 27 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx_dois_bytes.sv | 106 ++++++++++
 tb/tb_uart_tx_dois_bytes.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART constants and FSM state encoding for the TX/RX stages.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int   UART_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud
  localparam int   UART_DATA_BITS    = 8;
  localparam logic UART_IDLE_LEVEL   = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    DONE      = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_dois_bytes_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_dois_bytes_if
// Brief   : Request/status bundle between the sensor stage and the 2-byte TX.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_dois_bytes_if;

  logic       start;
  logic [7:0] byte_comando;
  logic [7:0] byte_valor;
  logic       busy;
  logic       tx;
  logic       done;

  modport master (
    output start, byte_comando, byte_valor,
    input  busy, tx, done
  );

  modport slave (
    input  start, byte_comando, byte_valor,
    output busy, tx, done
  );

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Bit-period counter; tick is high on the last cycle of each bit.
// Revision: 1.0 - initial release
// ============================================================================
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int               c_WIDTH = $clog2(CLKS_PER_BIT);
  localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(CLKS_PER_BIT - 1);

  logic [c_WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || (r_count == c_LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_dois_bytes.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_dois_bytes
// Brief   : 8N1 transmitter sending command byte then value byte back-to-back.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_dois_bytes
  import uart_pkg::*;
#(
  parameter int   CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter logic IDLE_LEVEL   = UART_IDLE_LEVEL
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_tx_dois_bytes_if.slave  bus
);

  localparam logic [2:0] c_LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t r_state;
  uart_state_t w_nextState;
  logic [15:0] r_data;
  logic        r_byteIdx;
  logic [2:0]  r_bitIdx;
  logic        w_tick;
  logic        w_clear;
  logic        w_txBit;

  // Counter restarts on every state entry so each state owns whole bit periods.
  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baudTick (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (bus.start) w_nextState = START_BIT;
      START_BIT: if (w_tick) w_nextState = DATA_BITS;
      DATA_BITS: if (w_tick && (r_bitIdx == c_LAST_BIT)) w_nextState = STOP_BIT;
      STOP_BIT:  if (w_tick) w_nextState = r_byteIdx ? DONE : START_BIT;
      DONE:      w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  assign w_clear = (r_state == IDLE) || (w_nextState != r_state);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_byteIdx <= 1'b0;
      r_bitIdx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_data    <= {bus.byte_valor, bus.byte_comando};
            r_byteIdx <= 1'b0;
            r_bitIdx  <= '0;
          end
        end
        START_BIT: r_bitIdx <= '0;
        DATA_BITS: if (w_tick) r_bitIdx <= r_bitIdx + 1'b1;
        STOP_BIT:  if (w_tick && !r_byteIdx) r_byteIdx <= 1'b1;
        default:   ;
      endcase
    end
  end

  // Byte index selects the upper half of the latched word for the second frame.
  assign w_txBit = r_data[{r_byteIdx, r_bitIdx}];

  always_comb begin
    bus.tx   = IDLE_LEVEL;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      START_BIT: begin
        bus.tx   = ~IDLE_LEVEL;
        bus.busy = 1'b1;
      end
      DATA_BITS: begin
        bus.tx   = w_txBit;
        bus.busy = 1'b1;
      end
      STOP_BIT:  bus.busy = 1'b1;
      DONE:      bus.done = 1'b1;
      default:   ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_dois_bytes.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_dois_bytes
// Brief   : Randomised self-checking bench against a bit-slot waveform model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_dois_bytes;

  localparam int CPB   = 4;
  localparam int FRAME = 20 * CPB;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  uart_tx_dois_bytes_if bus();

  uart_tx_dois_bytes #(
    .CLKS_PER_BIT (CPB),
    .IDLE_LEVEL   (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line level for each cycle of a two-frame transfer, from slot arithmetic.
  function automatic logic [FRAME-1:0] expected_wave(input logic [7:0] cmd, input logic [7:0] val);
    logic [FRAME-1:0] w;
    w = '0;
    for (int k = 0; k < FRAME; k++) begin
      int slot;
      int pos;
      logic [7:0] b;
      slot = k / CPB;
      pos  = slot % 10;
      b    = (slot < 10) ? cmd : val;
      if (pos == 0)      w[k] = 1'b0;
      else if (pos == 9) w[k] = 1'b1;
      else               w[k] = b[pos-1];
    end
    return w;
  endfunction

  task automatic pulse_start(input logic [7:0] cmd, input logic [7:0] val);
    @(negedge clock);
    bus.byte_comando = cmd;
    bus.byte_valor   = val;
    bus.start        = 1'b1;
    @(negedge clock);
    bus.start        = 1'b0;
  endtask

  // Records FRAME cycles starting at the first low cycle; ends on the negedge after.
  task automatic capture(output logic [FRAME-1:0] wave, output bit found, output bit busyOk,
                         output int doneSeen, output logic doneEnd);
    int waitCnt;
    waitCnt  = 0;
    wave     = '0;
    busyOk   = 1'b1;
    doneSeen = 0;
    doneEnd  = 1'b0;
    while (bus.tx !== 1'b0 && waitCnt < 100) begin
      @(negedge clock);
      waitCnt++;
    end
    found = (bus.tx === 1'b0);
    if (found) begin
      for (int i = 0; i < FRAME; i++) begin
        wave[i] = bus.tx;
        if (bus.busy !== 1'b1) busyOk = 1'b0;
        if (bus.done === 1'b1) doneSeen++;
        @(negedge clock);
      end
      doneEnd = bus.done;
    end
  endtask

  task automatic quiet_cycles(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.tx !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (bus.tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    reset = 1'b0;
    quiet_cycles(50, bad);
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_idle: %0d non-idle cycles, expected 0", bad); end
  endtask

  task automatic test_basic;
    logic [7:0]       cmds[5];
    logic [7:0]       vals[5];
    logic [FRAME-1:0] wave;
    logic [FRAME-1:0] exp;
    bit               found, busyOk;
    int               doneSeen;
    logic             doneEnd;
    cmds[0] = 8'h01; vals[0] = 8'hA5;
    cmds[1] = 8'h00; vals[1] = 8'hFF;
    for (int t = 2; t < 5; t++) begin
      cmds[t] = 8'($urandom);
      vals[t] = 8'($urandom);
    end
    for (int t = 0; t < 5; t++) begin
      pulse_start(cmds[t], vals[t]);
      checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL basic_latency[%0d]: tx=%b expected 0", t, bus.tx); end
      capture(wave, found, busyOk, doneSeen, doneEnd);
      exp = expected_wave(cmds[t], vals[t]);
      checks++; if (!found) begin errors++; $display("FAIL basic_found[%0d]: no start bit seen", t); end
      checks++; if (wave !== exp) begin errors++; $display("FAIL basic_wave[%0d]: got %h expected %h", t, wave, exp); end
      checks++; if (!busyOk) begin errors++; $display("FAIL basic_busy[%0d]: busy dropped during transfer", t); end
      checks++; if (doneSeen !== 0) begin errors++; $display("FAIL basic_early_done[%0d]: %0d early pulses, expected 0", t, doneSeen); end
      checks++; if (doneEnd !== 1'b1) begin errors++; $display("FAIL basic_done80[%0d]: done=%b expected 1", t, doneEnd); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy[%0d]: busy=%b expected 0", t, bus.busy); end
      @(negedge clock);
      checks++; if (bus.done !== 1'b0 || bus.tx !== 1'b1) begin errors++; $display("FAIL basic_after[%0d]: done=%b tx=%b expected 0/1", t, bus.done, bus.tx); end
    end
  endtask

  task automatic test_ignore_busy;
    logic [7:0]       cmd, val;
    logic [FRAME-1:0] wave;
    bit               found, busyOk;
    int               doneSeen, bad;
    logic             doneEnd;
    cmd = 8'($urandom);
    val = 8'($urandom);
    pulse_start(cmd, val);
    fork
      capture(wave, found, busyOk, doneSeen, doneEnd);
      begin
        repeat (30) @(negedge clock);
        bus.byte_comando = 8'hFF;
        bus.byte_valor   = 8'hFF;
        bus.start        = 1'b1;
        @(negedge clock);
        bus.start        = 1'b0;
      end
    join
    checks++; if (wave !== expected_wave(cmd, val)) begin errors++; $display("FAIL busy_wave: got %h expected %h", wave, expected_wave(cmd, val)); end
    checks++; if (doneSeen !== 0 || doneEnd !== 1'b1) begin errors++; $display("FAIL busy_done: early=%0d end=%b expected 0/1", doneSeen, doneEnd); end
    // Start asserted during the DONE cycle must also be dropped.
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    quiet_cycles(100, bad);
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_no_queue: %0d non-idle cycles, expected 0", bad); end
  endtask

  task automatic test_continuous;
    logic [FRAME-1:0] wave1, wave2, exp;
    bit               found, busyOk;
    int               doneSeen, gap, bad;
    logic             doneEnd1, doneEnd2;
    exp = expected_wave(8'h00, 8'hFF);
    @(negedge clock);
    bus.byte_comando = 8'h00;
    bus.byte_valor   = 8'hFF;
    bus.start        = 1'b1;
    @(negedge clock);
    capture(wave1, found, busyOk, doneSeen, doneEnd1);
    checks++; if (wave1 !== exp || doneEnd1 !== 1'b1) begin errors++; $display("FAIL cont_first: wave %h done %b expected %h 1", wave1, doneEnd1, exp); end
    gap = 0;
    while (bus.tx !== 1'b0 && gap < 10) begin
      @(negedge clock);
      gap++;
    end
    // DONE cycle then one IDLE cycle before the next start bit.
    checks++; if (gap !== 2) begin errors++; $display("FAIL cont_gap: got %0d cycles expected 2", gap); end
    fork
      capture(wave2, found, busyOk, doneSeen, doneEnd2);
      begin
        repeat (40) @(negedge clock);
        bus.start = 1'b0;
      end
    join
    checks++; if (wave2 !== exp || doneEnd2 !== 1'b1) begin errors++; $display("FAIL cont_second: wave %h done %b expected %h 1", wave2, doneEnd2, exp); end
    quiet_cycles(50, bad);
    checks++; if (bad !== 0) begin errors++; $display("FAIL cont_stop: %0d non-idle cycles, expected 0", bad); end
  endtask

  task automatic test_input_change;
    logic [7:0]       cmd;
    logic [FRAME-1:0] wave;
    bit               found, busyOk;
    int               doneSeen;
    logic             doneEnd;
    cmd = 8'($urandom);
    pulse_start(cmd, 8'h3C);
    fork
      capture(wave, found, busyOk, doneSeen, doneEnd);
      begin
        repeat (10) @(negedge clock);
        bus.byte_valor   = 8'hC3;
        bus.byte_comando = ~cmd;
      end
    join
    checks++; if (wave !== expected_wave(cmd, 8'h3C)) begin errors++; $display("FAIL change_wave: got %h expected %h", wave, expected_wave(cmd, 8'h3C)); end
    checks++; if (doneEnd !== 1'b1) begin errors++; $display("FAIL change_done: got %b expected 1", doneEnd); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0]       cmd, val;
    logic [FRAME-1:0] wave;
    bit               found, busyOk;
    int               doneSeen, bad;
    logic             doneEnd;
    cmd = 8'($urandom);
    val = 8'($urandom);
    pulse_start(cmd, val);
    // Second frame bit 3 occupies cycles 56..59 of the transfer.
    repeat (57) @(negedge clock);
    checks++; if (bus.tx !== val[3]) begin errors++; $display("FAIL mid_bit3: tx=%b expected %b", bus.tx, val[3]); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_async: tx=%b busy=%b expected 1/0", bus.tx, bus.busy); end
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.tx !== 1'b1) bad++;
    end
    reset = 1'b0;
    begin
      int bad2;
      quiet_cycles(100, bad2);
      bad += bad2;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mid_abandon: %0d non-idle cycles, expected 0", bad); end
    cmd = 8'($urandom);
    val = 8'($urandom);
    pulse_start(cmd, val);
    capture(wave, found, busyOk, doneSeen, doneEnd);
    checks++; if (wave !== expected_wave(cmd, val)) begin errors++; $display("FAIL mid_fresh_wave: got %h expected %h", wave, expected_wave(cmd, val)); end
    checks++; if (doneEnd !== 1'b1 || doneSeen !== 0) begin errors++; $display("FAIL mid_fresh_done: end=%b early=%0d expected 1/0", doneEnd, doneSeen); end
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.byte_comando = 8'h00;
    bus.byte_valor   = 8'h00;
    test_reset();
    test_basic();
    test_ignore_busy();
    test_continuous();
    test_input_change();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
